// File: rtl/genius_pkg.sv
// Shared Genius game types.
//   color_t            : colour stored per sequence entry
//   velocity_t         : pace selection from the speed switch
//   led_player_state_t : LED playback FSM states
//   max4()             : largest of four values, used to size timers
//   color_to_led()     : colour -> one-hot {yellow, blue, red, green}
package genius_pkg;

   typedef enum logic [1:0] {
      COLOR_GREEN  = 2'd0,
      COLOR_RED    = 2'd1,
      COLOR_BLUE   = 2'd2,
      COLOR_YELLOW = 2'd3
   } color_t;

   typedef enum logic {
      VELOCITY_SLOW = 1'b0,
      VELOCITY_FAST = 1'b1
   } velocity_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_ON    = 3'd3,
      S_OFF   = 3'd4,
      S_DONE  = 3'd5
   } led_player_state_t;

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Bit order {yellow, blue, red, green}
   function automatic logic [3:0] color_to_led(input color_t c);
      logic [3:0] v;
      v = '0;
      unique case (c)
         COLOR_GREEN:  v = 4'b0001;
         COLOR_RED:    v = 4'b0010;
         COLOR_BLUE:   v = 4'b0100;
         COLOR_YELLOW: v = 4'b1000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/genius_phase_timer.sv
// Phase down-counter for the LED player.
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : load load_val_i into the counter (wins over en_i)
//   load_val_i  : value loaded, TW bits
//   en_i        : decrement by one; holds at zero
//   zero_o      : counter is zero
module genius_phase_timer #(
   parameter int unsigned TW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [TW-1:0] load_val_i,
   input  logic          en_i,
   output logic          zero_o
);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/genius_led_player.sv
// Plays the stored Genius colour sequence on the four LEDs.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request playback (sampled only when idle)
//   abort         : synchronous cancel, no done pulse
//   len           : colours to play, clamped to 2**DATA_WIDTH
//   speed_switch  : pace select, captured at start
//   rd_addr       : sequence-memory read index
//   rd_data       : sequence-memory data, one cycle after rd_addr
//   busy, done    : playback active / one-cycle completion pulse
//   led_*         : registered one-hot colour LEDs
module genius_led_player
   import genius_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ON_SLOW    = 20,
   parameter int unsigned OFF_SLOW   = 10,
   parameter int unsigned ON_FAST    = 8,
   parameter int unsigned OFF_FAST   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH:0]   len,
   input  velocity_t             speed_switch,
   output logic [DATA_WIDTH-1:0] rd_addr,
   input  color_t                rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  led_green,
   output logic                  led_red,
   output logic                  led_blue,
   output logic                  led_yellow
);

   localparam int unsigned TW = $clog2(max4(ON_SLOW, OFF_SLOW, ON_FAST, OFF_FAST) + 1);
   localparam logic [TW-1:0] ON_SLOW_M1  = TW'(ON_SLOW - 1);
   localparam logic [TW-1:0] OFF_SLOW_M1 = TW'(OFF_SLOW - 1);
   localparam logic [TW-1:0] ON_FAST_M1  = TW'(ON_FAST - 1);
   localparam logic [TW-1:0] OFF_FAST_M1 = TW'(OFF_FAST - 1);
   localparam logic [DATA_WIDTH:0] LEN_MAX = {1'b1, {DATA_WIDTH{1'b0}}};

   led_player_state_t     state_q, state_d;
   logic [DATA_WIDTH:0]   len_q, len_d;
   velocity_t             spd_q, spd_d;
   logic [DATA_WIDTH-1:0] idx_q, idx_d;
   color_t                color_q, color_d;
   logic [3:0]            led_q, led_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0]         tmr_val;
   logic [TW-1:0]         t_on_m1, t_off_m1;
   logic [DATA_WIDTH:0]   len_clamp;
   logic                  last_colour;

   assign t_on_m1     = (spd_q == VELOCITY_SLOW) ? ON_SLOW_M1  : ON_FAST_M1;
   assign t_off_m1    = (spd_q == VELOCITY_SLOW) ? OFF_SLOW_M1 : OFF_FAST_M1;
   assign len_clamp   = (len > LEN_MAX) ? LEN_MAX : len;
   assign last_colour = ({1'b0, idx_q} == (len_q - 1'b1));

   genius_phase_timer #(.TW(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      spd_d    = spd_q;
      idx_d    = idx_q;
      color_d  = color_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  len_d   = len_clamp;
                  spd_d   = speed_switch;
                  idx_d   = '0;
                  state_d = (len_clamp == '0) ? S_DONE : S_FETCH;
               end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
               color_d  = rd_data;
               tmr_load = 1'b1;
               tmr_val  = t_on_m1;
               state_d  = S_ON;
            end
            S_ON: begin
               if (tmr_zero) begin
                  tmr_load = 1'b1;
                  tmr_val  = t_off_m1;
                  state_d  = S_OFF;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            S_OFF: begin
               if (tmr_zero) begin
                  if (last_colour) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = S_FETCH;
                  end
               end else begin
                  tmr_en = 1'b1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are registered from the current state, so they trail the FSM by
   // one cycle; abort clears them on the same edge it returns the FSM to idle.
   always_comb begin
      led_d  = ((state_q == S_ON) && !abort) ? color_to_led(color_q) : '0;
      busy_d = !abort && (state_q inside {S_FETCH, S_LOAD, S_ON, S_OFF});
      done_d = !abort && (state_q == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         spd_q   <= VELOCITY_SLOW;
         idx_q   <= '0;
         color_q <= COLOR_GREEN;
         led_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         spd_q   <= spd_d;
         idx_q   <= idx_d;
         color_q <= color_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign rd_addr    = idx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign led_green  = led_q[0];
   assign led_red    = led_q[1];
   assign led_blue   = led_q[2];
   assign led_yellow = led_q[3];

endmodule

// File: tb/tb_genius_led_player.sv
module tb_genius_led_player;
   import genius_pkg::*;

   localparam int unsigned DW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [DW:0]   len;
   velocity_t     speed_switch;
   logic [DW-1:0] rd_addr;
   color_t        rd_data;
   logic          busy, done;
   logic          led_green, led_red, led_blue, led_yellow;

   genius_led_player #(
      .DATA_WIDTH (DW),
      .ON_SLOW    (20),
      .OFF_SLOW   (10),
      .ON_FAST    (8),
      .OFF_FAST   (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .len          (len),
      .speed_switch (speed_switch),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .led_green    (led_green),
      .led_red      (led_red),
      .led_blue     (led_blue),
      .led_yellow   (led_yellow)
   );

   always #5 clk = ~clk;

   // Sequence memory, synchronous read
   color_t mem [16];
   always @(posedge clk) rd_data <= mem[rd_addr];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
   endtask

   // Scoreboard: kind 0 = LED change, kind 1 = done pulse
   typedef struct {
      int unsigned kind;
      int unsigned cyc;
      logic [3:0]  led;
      int unsigned addr;
   } evt_t;
   evt_t exp_q[$];

   function automatic logic [3:0] onehot_of(input color_t c);
      case (c)
         COLOR_GREEN:  return 4'b0001;
         COLOR_RED:    return 4'b0010;
         COLOR_BLUE:   return 4'b0100;
         default:      return 4'b1000;
      endcase
   endfunction

   bit         mon_en = 1'b0;
   logic [3:0] prev_led = '0;

   task automatic match_evt(input int unsigned kind, input logic [3:0] led_now);
      evt_t e;
      if (exp_q.size() == 0) begin
         check_eq(kind == 0 ? "unexpected_led_change" : "unexpected_done", exp_q.size(), 1);
      end else begin
         e = exp_q.pop_front();
         check_eq("evt_kind",  kind, e.kind);
         check_eq("evt_cycle", cyc, e.cyc);
         check_eq("evt_led",   led_now, e.led);
         check_eq("evt_addr",  rd_addr, e.addr);
         if (kind == 1)           check_eq("busy_at_done", busy, 0);
         else if (led_now != '0)  check_eq("busy_at_led",  busy, 1);
      end
   endtask

   always @(negedge clk) begin
      logic [3:0] led_now;
      led_now = {led_yellow, led_blue, led_red, led_green};
      if (mon_en) begin
         if ($countones(led_now) > 1) check_eq("led_onehot", $countones(led_now), 1);
         if (led_now != prev_led) match_evt(0, led_now);
         if (done) match_evt(1, led_now);
      end
      prev_led = led_now;
   end

   // Drive a start and push every expected LED change and the done pulse.
   task automatic start_play(input int unsigned n, input velocity_t spd, output int unsigned s);
      int unsigned ton, toff, p, neff;
      ton  = (spd == VELOCITY_SLOW) ? 20 : 8;
      toff = (spd == VELOCITY_SLOW) ? 10 : 4;
      p    = ton + toff + 2;
      neff = (n > 16) ? 16 : n;
      @(negedge clk);
      start        = 1'b1;
      len          = n[DW:0];
      speed_switch = spd;
      s            = cyc + 1;
      for (int unsigned k = 0; k < neff; k++) begin
         exp_q.push_back('{0, s + 3 + k*p,       onehot_of(mem[k]), k});
         exp_q.push_back('{0, s + 3 + k*p + ton, 4'b0000,           k});
      end
      if (neff == 0) exp_q.push_back('{1, s + 1, 4'b0000, 0});
      else           exp_q.push_back('{1, s + 3 + (neff-1)*p + ton + toff, 4'b0000, neff-1});
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_eq("busy_after_start", busy, (neff > 0) ? 1 : 0);
   endtask

   task automatic wait_drain(input int unsigned budget);
      for (int unsigned i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      check_eq("scoreboard_drained", exp_q.size(), 0);
      repeat (4) @(negedge clk);
      check_eq("busy_idle", busy, 0);
   endtask

   initial begin
      int unsigned s, p;
      rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0; speed_switch = VELOCITY_SLOW;
      for (int i = 0; i < 16; i++) mem[i] = COLOR_GREEN;
      repeat (3) @(negedge clk);
      check_eq("rst_led",   {led_yellow, led_blue, led_red, led_green}, 0);
      check_eq("rst_busy",  busy, 0);
      check_eq("rst_done",  done, 0);
      check_eq("rst_addr",  rd_addr, 0);
      rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      // Reset in the middle of the first colour's on-phase
      mem[0] = COLOR_GREEN; mem[1] = COLOR_RED; mem[2] = COLOR_BLUE;
      start_play(3, VELOCITY_SLOW, s);
      for (int unsigned i = 0; i < 50 && !led_green; i++) @(negedge clk);
      check_eq("pre_rst_green", led_green, 1);
      mon_en = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("midrst_led",  {led_yellow, led_blue, led_red, led_green}, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_addr", rd_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      mon_en = 1'b1;

      // Full three-colour slow playback
      start_play(3, VELOCITY_SLOW, s);
      wait_drain(200);

      // Single fast colour
      mem[0] = COLOR_YELLOW;
      start_play(1, VELOCITY_FAST, s);
      wait_drain(60);

      // Empty sequence
      start_play(0, VELOCITY_SLOW, s);
      check_eq("len0_addr", rd_addr, 0);
      wait_drain(20);

      // Over-long request clamps to 16 colours
      for (int i = 0; i < 16; i++) mem[i] = color_t'($urandom_range(0, 3));
      start_play(17, VELOCITY_FAST, s);
      wait_drain(16*14 + 40);

      // Start and speed changes during playback are ignored
      mem[0] = COLOR_RED; mem[1] = COLOR_BLUE; mem[2] = COLOR_GREEN;
      start_play(3, VELOCITY_SLOW, s);
      repeat (30) @(negedge clk);
      start = 1'b1; len = 5'd1; speed_switch = VELOCITY_FAST;
      repeat (2) @(negedge clk);
      start = 1'b0; speed_switch = VELOCITY_SLOW;
      repeat (3) @(negedge clk);
      speed_switch = VELOCITY_FAST;
      wait_drain(200);

      // Abort during the second colour's on-phase, then replay from index 0
      start_play(3, VELOCITY_FAST, s);
      p = 8 + 4 + 2;
      for (int unsigned i = 0; i < 100 && cyc != s + 3 + p + 5; i++) @(negedge clk);
      check_eq("abort_reached", cyc, s + 3 + p + 5);
      abort = 1'b1;
      exp_q.delete();
      exp_q.push_back('{0, cyc + 1, 4'b0000, 1});
      @(negedge clk);
      abort = 1'b0;
      check_eq("abort_busy", busy, 0);
      repeat (20) @(negedge clk);
      check_eq("abort_no_done", exp_q.size(), 0);
      start_play(3, VELOCITY_FAST, s);
      wait_drain(100);

      // abort wins over a simultaneous start
      @(negedge clk);
      start = 1'b1; abort = 1'b1; len = 5'd2;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check_eq("abort_start_busy", busy, 0);
      repeat (10) @(negedge clk);
      check_eq("abort_start_quiet", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
